// File: rtl/blur_frame_sequencer.sv
// -----------------------------------------------------------------------------
// blur_frame_sequencer
// Frame-level controller for the Gaussian-blur stage. It lets exactly
// WIDTH*HEIGHT pixels move from the source FIFO into the blur input FIFO for
// each frame. It counts blur output writes, detects frame completion or an
// output stall, and reports done/error status. In continuous mode it re-arms
// itself after every frame.
//
// Ports
//   clock, reset           system clock, asynchronous active-high reset
//   start, continuous      frame start pulse; auto re-arm after DONE
//   abort                  pulse; returns to IDLE from any state
//   src_rd_en/src_empty/src_dout    show-ahead source FIFO read side
//   blk_wr_en/blk_full/blk_din      blur input FIFO write side
//   res_wr_en/res_full     blur output FIFO write side (monitored only)
//   busy, done, error      status: active frame, completion pulse, sticky timeout
//   sof, eol               first pixel of frame / last pixel of line markers
//   frame_count            completed frames (wraps)
// -----------------------------------------------------------------------------
module blur_frame_sequencer #(
    parameter int unsigned WIDTH   = 1280,
    parameter int unsigned HEIGHT  = 720,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    output logic        src_rd_en,
    input  logic        src_empty,
    input  logic [7:0]  src_dout,
    output logic        blk_wr_en,
    input  logic        blk_full,
    output logic [7:0]  blk_din,
    input  logic        res_wr_en,
    input  logic        res_full,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        sof,
    output logic        eol,
    output logic [15:0] frame_count
);

    localparam int unsigned PIXEL_COUNT = WIDTH * HEIGHT;
    localparam int unsigned CNT_W       = $clog2(PIXEL_COUNT + 1);
    localparam int unsigned COL_W       = $clog2(WIDTH + 1);
    localparam int unsigned ROW_W       = $clog2(HEIGHT + 1);
    localparam int unsigned STALL_W     = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   PIX_TOTAL  = CNT_W'(PIXEL_COUNT);
    localparam logic [CNT_W-1:0]   PIX_LAST   = CNT_W'(PIXEL_COUNT - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(WIDTH - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 error_q, error_d;
    logic [15:0]          frame_count_q, frame_count_d;

    logic xfer;
    logic oev;

    // State and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            stall_q       <= '0;
            error_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            stall_q       <= stall_d;
            error_q       <= error_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next-state, counter update and transfer gating
    always_comb begin
        state_d       = state_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        col_d         = col_q;
        row_d         = row_q;
        stall_d       = stall_q;
        error_d       = error_q;
        frame_count_d = frame_count_q;
        xfer          = 1'b0;
        sof           = 1'b0;
        eol           = 1'b0;
        done          = 1'b0;
        busy          = (state_q != S_IDLE);
        oev           = res_wr_en & ~res_full;

        // abort masks the transfer in the same cycle it is seen
        if ((state_q == S_FEED) && !src_empty && !blk_full &&
            (in_cnt_q < PIX_TOTAL) && !abort) begin
            xfer = 1'b1;
        end

        if (xfer) begin
            sof      = (in_cnt_q == '0);
            eol      = (col_q == COL_LAST);
            in_cnt_d = in_cnt_q + CNT_W'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // Output writes count during FEED and DRAIN, saturating at a full frame
        if (((state_q == S_FEED) || (state_q == S_DRAIN)) && oev &&
            (out_cnt_q != PIX_TOTAL)) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FEED;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                    stall_d   = '0;
                    error_d   = 1'b0;
                end
            end
            S_FEED: begin
                stall_d = '0;
                if (xfer && (in_cnt_q == PIX_LAST)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // completion uses the count including this cycle's write
                if (out_cnt_d == PIX_TOTAL) begin
                    state_d = S_DONE;
                    stall_d = '0;
                end else if (oev) begin
                    stall_d = '0;
                end else if (stall_q == STALL_LAST) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            S_DONE: begin
                done          = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                if (continuous) begin
                    state_d   = S_FEED;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                    stall_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort wins over every other transition and suppresses completion
        if (abort) begin
            state_d       = S_IDLE;
            done          = 1'b0;
            frame_count_d = frame_count_q;
            error_d       = error_q;
        end
    end

    assign src_rd_en   = xfer;
    assign blk_wr_en   = xfer;
    assign blk_din     = xfer ? src_dout : 8'h00;
    assign error       = error_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_blur_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_blur_frame_sequencer
// Directed bench for blur_frame_sequencer with a 4x3 frame and TIMEOUT=8.
// A queue models the show-ahead source FIFO; transfers, markers and done
// pulses are logged per cycle and compared against hand-derived values.
// -----------------------------------------------------------------------------
module tb_blur_frame_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        continuous;
    logic        abort;
    logic        src_rd_en;
    logic        src_empty;
    logic [7:0]  src_dout;
    logic        blk_wr_en;
    logic        blk_full;
    logic [7:0]  blk_din;
    logic        res_wr_en;
    logic        res_full;
    logic        busy;
    logic        done;
    logic        error;
    logic        sof;
    logic        eol;
    logic [15:0] frame_count;

    blur_frame_sequencer #(
        .WIDTH  (4),
        .HEIGHT (3),
        .TIMEOUT(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .src_rd_en  (src_rd_en),
        .src_empty  (src_empty),
        .src_dout   (src_dout),
        .blk_wr_en  (blk_wr_en),
        .blk_full   (blk_full),
        .blk_din    (blk_din),
        .res_wr_en  (res_wr_en),
        .res_full   (res_full),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .sof        (sof),
        .eol        (eol),
        .frame_count(frame_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]  srcq[$];
    logic [7:0]  din_log[$];
    logic        gap;
    int          cyc_no;
    int          xfer_n;
    int          done_n;
    int          first_x;
    int          last_x;
    logic [63:0] sof_mask;
    logic [63:0] eol_mask;
    logic        s_rd, s_wr, s_sof, s_eol, s_done, s_busy, s_err;
    logic [7:0]  s_din;
    logic [7:0]  tmp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        din_log.delete();
        xfer_n   = 0;
        done_n   = 0;
        first_x  = -1;
        last_x   = -1;
        sof_mask = '0;
        eol_mask = '0;
    endtask

    task automatic fill_src(input int n);
        srcq.delete();
        for (int i = 0; i < n; i++) srcq.push_back(8'(i));
    endtask

    // One clock cycle: present source, sample outputs, clock edge, pop on read
    task automatic cyc();
        src_empty = gap || (srcq.size() == 0);
        src_dout  = (srcq.size() != 0) ? srcq[0] : 8'h00;
        #1;
        s_rd   = src_rd_en;
        s_wr   = blk_wr_en;
        s_din  = blk_din;
        s_sof  = sof;
        s_eol  = eol;
        s_done = done;
        s_busy = busy;
        s_err  = error;
        chk("strobe_legal", 64'({s_rd & src_empty, s_wr & blk_full, s_rd ^ s_wr}), 64'd0);
        if (!s_wr) chk("din_idle", 64'(s_din), 64'd0);
        if (s_wr) begin
            if (xfer_n == 0) first_x = cyc_no;
            last_x = cyc_no;
            din_log.push_back(s_din);
            if (s_sof) sof_mask = sof_mask | (64'd1 << xfer_n);
            if (s_eol) eol_mask = eol_mask | (64'd1 << xfer_n);
            xfer_n++;
        end
        if (s_done) done_n++;
        @(posedge clock);
        #1;
        if (s_rd) tmp = srcq.pop_front();
        cyc_no++;
    endtask

    int          st_cyc;
    logic        prev_done;
    logic [63:0] exp_eol;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        abort      = 1'b0;
        blk_full   = 1'b0;
        res_wr_en  = 1'b0;
        res_full   = 1'b0;
        gap        = 1'b0;
        cyc_no     = 0;
        fill_src(20);
        src_empty  = 1'b0;
        src_dout   = 8'h00;
        clear_log();

        // Reset state
        @(posedge clock);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_rd", 64'({src_rd_en, blk_wr_en, sof, eol}), 64'd0);
        chk("rst_din", 64'(blk_din), 64'd0);
        chk("rst_fc", 64'(frame_count), 64'd0);
        reset = 1'b0;

        // Frame 1: 12 consecutive transfers out of 20 queued pixels
        st_cyc = cyc_no;
        start  = 1'b1;
        cyc();
        start = 1'b0;
        repeat (12) cyc();
        chk("f1_xfers", 64'(xfer_n), 64'd12);
        chk("f1_first", 64'(first_x), 64'(st_cyc + 1));
        chk("f1_span", 64'(last_x - first_x), 64'd11);
        chk("f1_sof", sof_mask, 64'h1);
        chk("f1_eol", eol_mask, 64'h888);
        chk("f1_left", 64'(srcq.size()), 64'd8);
        if (xfer_n == 12) for (int i = 0; i < 12; i++) chk("f1_din", 64'(din_log[i]), 64'(i));
        // 12 output writes in DRAIN
        res_wr_en = 1'b1;
        repeat (12) cyc();
        res_wr_en = 1'b0;
        chk("f1_no_early_done", 64'(done_n), 64'd0);
        cyc();
        chk("f1_done", 64'(s_done), 64'd1);
        chk("f1_busy_done", 64'(s_busy), 64'd1);
        chk("f1_fc", 64'(frame_count), 64'd1);
        cyc();
        chk("f1_idle", 64'({s_busy, s_done, s_err}), 64'd0);

        // Frame 2: backpressure and source gaps; output completes during FEED
        fill_src(12);
        clear_log();
        start     = 1'b1;
        res_wr_en = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 80 && xfer_n < 12; i++) begin
            blk_full = (i % 2) == 1;
            gap      = (i % 5) == 2;
            cyc();
        end
        blk_full  = 1'b0;
        gap       = 1'b0;
        res_wr_en = 1'b0;
        chk("f2_xfers", 64'(xfer_n), 64'd12);
        chk("f2_left", 64'(srcq.size()), 64'd0);
        if (xfer_n == 12) for (int i = 0; i < 12; i++) chk("f2_din", 64'(din_log[i]), 64'(i));
        cyc();
        chk("f2_drain_cycle", 64'({s_busy, s_done}), 64'b10);
        cyc();
        chk("f2_done", 64'(s_done), 64'd1);
        chk("f2_fc", 64'(frame_count), 64'd2);
        cyc();
        chk("f2_idle", 64'(s_busy), 64'd0);

        // Frame 3: only 10 output writes, then silence until timeout
        fill_src(12);
        clear_log();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (12) cyc();
        res_wr_en = 1'b1;
        res_full  = 1'b1;
        cyc();
        res_full = 1'b0;
        repeat (10) cyc();
        res_wr_en = 1'b0;
        repeat (8) cyc();
        chk("f3_no_early_done", 64'(done_n), 64'd0);
        chk("f3_no_early_err", 64'(s_err), 64'd0);
        cyc();
        chk("f3_timeout_done", 64'(s_done), 64'd1);
        chk("f3_timeout_err", 64'(s_err), 64'd1);
        chk("f3_fc", 64'(frame_count), 64'd3);
        cyc();
        chk("f3_err_sticky", 64'({s_busy, s_err}), 64'b01);

        // Continuous: three frames back to back; start clears error
        fill_src(36);
        clear_log();
        continuous = 1'b1;
        start      = 1'b1;
        res_wr_en  = 1'b1;
        cyc();
        start = 1'b0;
        chk("cont_err_clear", 64'(error), 64'd0);
        prev_done = 1'b0;
        for (int i = 0; i < 100 && done_n < 3; i++) begin
            cyc();
            if (prev_done) chk("cont_feed_after_done", 64'(s_wr), 64'd1);
            prev_done = s_done;
        end
        chk("cont_dones", 64'(done_n), 64'd3);
        chk("cont_xfers", 64'(xfer_n), 64'd36);
        chk("cont_fc", 64'(frame_count), 64'd6);
        chk("cont_sof", sof_mask, (64'd1 << 0) | (64'd1 << 12) | (64'd1 << 24));
        exp_eol = '0;
        for (int i = 0; i < 36; i++) if ((i % 4) == 3) exp_eol = exp_eol | (64'd1 << i);
        chk("cont_eol", eol_mask, exp_eol);
        chk("cont_err", 64'(error), 64'd0);
        continuous = 1'b0;
        res_wr_en  = 1'b0;
        abort      = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        chk("cont_abort_idle", 64'(s_busy), 64'd0);
        chk("cont_abort_fc", 64'(frame_count), 64'd6);

        // Abort after the 5th transfer, then restart from pixel 5
        fill_src(20);
        clear_log();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_masks_xfer", 64'(s_wr), 64'd0);
        cyc();
        chk("abort_idle", 64'(s_busy), 64'd0);
        chk("abort_xfers", 64'(xfer_n), 64'd5);
        chk("abort_left", 64'(srcq.size()), 64'd15);
        chk("abort_no_done", 64'(done_n), 64'd0);
        chk("abort_fc", 64'(frame_count), 64'd6);
        clear_log();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (12) cyc();
        chk("restart_xfers", 64'(xfer_n), 64'd12);
        if (xfer_n == 12) begin
            chk("restart_first_pix", 64'(din_log[0]), 64'd5);
            chk("restart_last_pix", 64'(din_log[11]), 64'd16);
        end
        chk("restart_sof", sof_mask, 64'h1);
        // Abort during DRAIN: no completion recorded
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        chk("drain_abort_idle", 64'(s_busy), 64'd0);
        chk("drain_abort_no_done", 64'(done_n), 64'd0);
        chk("drain_abort_fc", 64'(frame_count), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
